// File: rtl/fp16_arb_pkg.sv
// rtl/fp16_arb_pkg.sv - shared types, widths and round-robin picker for fp16_add_arbiter
package fp16_arb_pkg;

   localparam int FP16_W        = 16;
   localparam int FP16_SIGN_BIT = 15;
   localparam int MAX_REQ       = 8;

   typedef logic [FP16_W-1:0] fp16_t;
   typedef logic [2:0]        tag_t;

   // Returns {found, index}: first set bit of mask at or after ptr, wrapping at n.
   function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] mask,
                                          input tag_t ptr,
                                          input int unsigned n);
      logic [3:0] pick;
      logic [3:0] idx;
      pick = '0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx >= 4'(n))
            idx = idx - 4'(n);
         if (k < int'(n) && !pick[3] && mask[idx[2:0]])
            pick = {1'b1, idx[2:0]};
      end
      return pick;
   endfunction

endpackage

// File: rtl/fp16_arb_tag_fifo.sv
// rtl/fp16_arb_tag_fifo.sv - synchronous tag FIFO recording which requester owns each in-flight adder op
module fp16_arb_tag_fifo
   import fp16_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  tag_t push_tag,
   input  logic pop,
   output tag_t pop_tag,
   output logic full,
   output logic empty,
   output logic err
);

   localparam tag_t LAST = tag_t'(DEPTH - 1);

   tag_t       mem [MAX_REQ];
   tag_t       wr_ptr;
   tag_t       rd_ptr;
   logic [3:0] count;
   logic       do_push;
   logic       do_pop;

   always_comb begin
      full    = (count == 4'(DEPTH));
      empty   = (count == 4'd0);
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      err     = pop & empty;
      pop_tag = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_tag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + tag_t'(1);
         if (do_pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + tag_t'(1);
         count <= count + 4'(do_push) - 4'(do_pop);
      end
   end

endmodule

// File: rtl/fp16_add_arbiter.sv
// rtl/fp16_add_arbiter.sv - round-robin sharing of one fp16 adder; optional FP16_ARB_PERF_EN adds perf counters
module fp16_add_arbiter
   import fp16_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ADD_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [16*NUM_REQ-1:0]   req_a,
   input  logic [16*NUM_REQ-1:0]   req_b,
   input  logic [NUM_REQ-1:0]      req_sub,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [15:0]             rsp_res,
   output logic                    rsp_ovf,
   output logic                    add_valid,
   output logic [15:0]             add_a,
   output logic [15:0]             add_b,
   input  logic [15:0]             add_res,
   input  logic                    add_ovf,
   input  logic                    add_res_vld,
   output logic                    err_protocol
`ifdef FP16_ARB_PERF_EN
   ,
   output logic [31:0]             perf_ops,
   output logic [15:0]             perf_ovf
`endif
);

   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || ADD_LATENCY < 1) begin : g_bad_params
      $error("fp16_add_arbiter: NUM_REQ must be 2..8 and ADD_LATENCY >= 1");
   end

   logic [NUM_REQ-1:0] outstanding;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] rsp_onehot;
   tag_t               rr_ptr;
   tag_t               grant_idx;
   logic [3:0]         pick;
   logic               grant_vld;
   fp16_t              grant_a;
   fp16_t              grant_b;
   tag_t               fifo_tag;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_err;
   logic               fifo_pop;
   logic               rsp_take;
   logic               push_ovf;

   always_comb begin
      eligible  = req_valid & ~outstanding;
      pick      = rr_pick(8'(eligible), rr_ptr, NUM_REQ);
      grant_vld = pick[3] & ~rst;
      grant_idx = pick[2:0];
      req_ready = '0;
      grant_a   = '0;
      grant_b   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == tag_t'(i)) begin
            req_ready[i] = grant_vld;
            grant_a      = req_a[i*FP16_W +: FP16_W];
            // Subtraction is an add with B's sign flipped.
            grant_b      = req_b[i*FP16_W +: FP16_W] ^ {req_sub[i], {FP16_SIGN_BIT{1'b0}}};
         end
      end
   end

   always_comb begin
      fifo_pop   = add_res_vld & ~rst;
      rsp_take   = fifo_pop & ~fifo_empty;
      push_ovf   = grant_vld & fifo_full & ~rsp_take;
      rsp_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (fifo_tag == tag_t'(i))
            rsp_onehot[i] = 1'b1;
      end
   end

   fp16_arb_tag_fifo #(.DEPTH(NUM_REQ)) u_tag_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (grant_vld),
      .push_tag (grant_idx),
      .pop      (fifo_pop),
      .pop_tag  (fifo_tag),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .err      (fifo_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr      <= '0;
         outstanding <= '0;
         add_valid   <= 1'b0;
         add_a       <= '0;
         add_b       <= '0;
      end else begin
         add_valid <= grant_vld;
         if (grant_vld) begin
            rr_ptr <= (grant_idx == tag_t'(NUM_REQ - 1)) ? '0 : grant_idx + tag_t'(1);
            add_a  <= grant_a;
            add_b  <= grant_b;
         end
         // Clearing on the return edge lets the requester re-issue while its rsp_valid is high.
         outstanding <= (outstanding & ~(rsp_take ? rsp_onehot : '0)) | req_ready;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid    <= '0;
         rsp_res      <= '0;
         rsp_ovf      <= 1'b0;
         err_protocol <= 1'b0;
      end else begin
         rsp_valid <= rsp_take ? rsp_onehot : '0;
         if (rsp_take) begin
            rsp_res <= add_res;
            rsp_ovf <= add_ovf;
         end
         if (fifo_err || push_ovf)
            err_protocol <= 1'b1;
      end
   end

`ifdef FP16_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ops <= '0;
         perf_ovf <= '0;
      end else begin
         if (grant_vld && perf_ops != '1)
            perf_ops <= perf_ops + 32'd1;
         if (rsp_take && add_ovf && perf_ovf != '1)
            perf_ovf <= perf_ovf + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// tb/tb_fp16_add_arbiter.sv - directed scoreboard bench for fp16_add_arbiter with a registered adder model
module tb_fp16_add_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  req_sub;
   logic [3:0]  rsp_valid;
   logic [15:0] rsp_res;
   logic        rsp_ovf;
   logic        add_valid;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic [15:0] add_res;
   logic        add_ovf;
   logic        add_res_vld;
   logic        err_protocol;
   logic        inject_vld;
`ifdef FP16_ARB_PERF_EN
   logic [31:0] perf_ops;
   logic [15:0] perf_ovf;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [3:0]  onehot;
      logic [15:0] res;
      logic        ovf;
   } exp_t;
   exp_t sb[$];

   logic [15:0] rr_a [4];
   logic [15:0] rr_b [4];
   logic [15:0] rr_r [4];

   always #5 clk = ~clk;

   fp16_add_arbiter #(.NUM_REQ(4), .ADD_LATENCY(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_sub      (req_sub),
      .rsp_valid    (rsp_valid),
      .rsp_res      (rsp_res),
      .rsp_ovf      (rsp_ovf),
      .add_valid    (add_valid),
      .add_a        (add_a),
      .add_b        (add_b),
      .add_res      (add_res),
      .add_ovf      (add_ovf),
      .add_res_vld  (add_res_vld),
      .err_protocol (err_protocol)
`ifdef FP16_ARB_PERF_EN
      ,
      .perf_ops     (perf_ops),
      .perf_ovf     (perf_ovf)
`endif
   );

   // Known half-precision sums for the operand pairs used below: {ovf, result}.
   function automatic logic [16:0] fp16_ref(input logic [15:0] a, input logic [15:0] b);
      case ({a, b})
         32'h4500_4100: return {1'b0, 16'h4780};
         32'h4500_C100: return {1'b0, 16'h4100};
         32'h7BFF_5200: return {1'b1, 16'h7C00};
         32'h3C00_3C00: return {1'b0, 16'h4000};
         32'h4000_4000: return {1'b0, 16'h4400};
         32'h4400_4400: return {1'b0, 16'h4800};
         32'h3C00_4000: return {1'b0, 16'h4200};
         default:       return {1'b0, 16'hDEAD};
      endcase
   endfunction

   // Registered adder beside the arbiter, sharing its reset.
   always @(posedge clk) begin
      if (rst) begin
         add_res_vld <= 1'b0;
         add_res     <= '0;
         add_ovf     <= 1'b0;
      end else begin
         add_res_vld <= add_valid | inject_vld;
         if (add_valid)
            {add_ovf, add_res} <= fp16_ref(add_a, add_b);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int idx, input logic [15:0] res, input logic ovf);
      exp_t e;
      e.onehot = 4'(1 << idx);
      e.res    = res;
      e.ovf    = ovf;
      sb.push_back(e);
   endtask

   task automatic set_req(input int idx, input logic [15:0] a, input logic [15:0] b, input logic sub);
      req_a[idx*16 +: 16] = a;
      req_b[idx*16 +: 16] = b;
      req_sub[idx]        = sub;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && rsp_valid !== 4'b0) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'h0);
         end else begin
            e = sb.pop_front();
            check("sb_rsp_valid", 32'(rsp_valid), 32'(e.onehot));
            check("sb_rsp_res", 32'(rsp_res), 32'(e.res));
            check("sb_rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
         end
      end
   end

   initial begin
      rst        = 1'b1;
      req_valid  = 4'b1111;
      req_a      = '0;
      req_b      = '0;
      req_sub    = '0;
      inject_vld = 1'b0;
      rr_a[0] = 16'h3C00; rr_b[0] = 16'h3C00; rr_r[0] = 16'h4000;
      rr_a[1] = 16'h4000; rr_b[1] = 16'h4000; rr_r[1] = 16'h4400;
      rr_a[2] = 16'h4400; rr_b[2] = 16'h4400; rr_r[2] = 16'h4800;
      rr_a[3] = 16'h3C00; rr_b[3] = 16'h4000; rr_r[3] = 16'h4200;

      // Reset state, with all requesters asking.
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_res", 32'(rsp_res), 32'h0);
      check("rst_rsp_ovf", 32'(rsp_ovf), 32'h0);
      check("rst_add_valid", 32'(add_valid), 32'h0);
      check("rst_add_a", 32'(add_a), 32'h0);
      check("rst_add_b", 32'(add_b), 32'h0);
      check("rst_err", 32'(err_protocol), 32'h0);
      req_valid = 4'b0;
      rst = 1'b0;
      @(negedge clk);

      // Single add from requester 0, exact latency.
      set_req(0, 16'h4500, 16'h4100, 1'b0);
      req_valid = 4'b0001;
      #1;
      check("add_ready0", 32'(req_ready), 32'h1);
      push_exp(0, 16'h4780, 1'b0);
      @(negedge clk);
      check("add_valid_t1", 32'(add_valid), 32'h1);
      check("add_a_t1", 32'(add_a), 32'h4500);
      check("add_b_t1", 32'(add_b), 32'h4100);
      check("add_ready_busy", 32'(req_ready), 32'h0);
      @(negedge clk);
      check("add_valid_t2", 32'(add_valid), 32'h0);
      check("add_a_hold", 32'(add_a), 32'h4500);
      check("rsp_early", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      check("rsp_t3_valid", 32'(rsp_valid), 32'h1);
      check("rsp_t3_res", 32'(rsp_res), 32'h4780);
      check("regrant_in_rsp_cycle", 32'(req_ready), 32'h1);
      req_valid = 4'b0;
      @(negedge clk);
      check("rsp_pulse_end", 32'(rsp_valid), 32'h0);
      check("rsp_res_hold", 32'(rsp_res), 32'h4780);

      // Subtract from requester 1.
      set_req(1, 16'h4500, 16'h4100, 1'b1);
      req_valid = 4'b0010;
      #1;
      check("sub_ready1", 32'(req_ready), 32'h2);
      push_exp(1, 16'h4100, 1'b0);
      @(negedge clk);
      req_valid = 4'b0;
      check("sub_add_b", 32'(add_b), 32'hC100);
      check("sub_add_a", 32'(add_a), 32'h4500);
      @(negedge clk);
      @(negedge clk);
      check("sub_rsp_valid", 32'(rsp_valid), 32'h2);
      @(negedge clk);

      // Overflow routed to requester 2.
      set_req(2, 16'h7BFF, 16'h5200, 1'b0);
      req_valid = 4'b0100;
      #1;
      check("ovf_ready2", 32'(req_ready), 32'h4);
      push_exp(2, 16'h7C00, 1'b1);
      @(negedge clk);
      req_valid = 4'b0;
      @(negedge clk);
      @(negedge clk);
      check("ovf_rsp_valid", 32'(rsp_valid), 32'h4);
      check("ovf_rsp_ovf", 32'(rsp_ovf), 32'h1);
`ifdef FP16_ARB_PERF_EN
      check("perf_ovf", 32'(perf_ovf), 32'h1);
      check("perf_ops", perf_ops, 32'h3);
`endif
      @(negedge clk);

      // Reset while requester 3's op is in flight.
      set_req(3, 16'h3C00, 16'h3C00, 1'b0);
      req_valid = 4'b1000;
      #1;
      check("mid_ready3", 32'(req_ready), 32'h8);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_add_valid", 32'(add_valid), 32'h0);
      check("mid_rst_ready", 32'(req_ready), 32'h0);
      rst = 1'b0;
      #1;
      check("mid_regrant3", 32'(req_ready), 32'h8);
      push_exp(3, 16'h4000, 1'b0);
      @(negedge clk);
      req_valid = 4'b0;
      check("mid_add_valid", 32'(add_valid), 32'h1);
      @(negedge clk);
      check("mid_no_stale_rsp", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      check("mid_rsp_valid", 32'(rsp_valid), 32'h8);
      check("mid_err", 32'(err_protocol), 32'h0);
      @(negedge clk);

      // Round robin from pointer 0 with all four requesters continuously valid.
      for (int i = 0; i < 4; i++)
         set_req(i, rr_a[i], rr_b[i], 1'b0);
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         check($sformatf("rr_grant_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
         push_exp(k % 4, rr_r[k % 4], 1'b0);
         @(negedge clk);
      end
      req_valid = 4'b0;
      repeat (5) @(negedge clk);
      check("rr_drained", 32'(sb.size()), 32'h0);

      // Adder result with no pending tag.
      inject_vld = 1'b1;
      @(negedge clk);
      inject_vld = 1'b0;
      @(negedge clk);
      check("perr_set", 32'(err_protocol), 32'h1);
      check("perr_no_rsp", 32'(rsp_valid), 32'h0);
      repeat (2) @(negedge clk);
      check("perr_sticky", 32'(err_protocol), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("perr_cleared", 32'(err_protocol), 32'h0);
      @(negedge clk);
      check("final_sb_empty", 32'(sb.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
